emg_fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one sample FIFO (B = ID_W+SAMPLE_W, W address bits) among N_CH EMG ADC channels.

---
 rtl/emg_arb_pkg.sv | 35 +++
 rtl/emg_fifo_wr_arbiter_rr_pick.sv | 43 ++++
 rtl/emg_fifo_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_emg_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emg_arb_pkg.sv
// ---------------------------------------------------------------------------
// emg_arb_pkg
//   Shared definitions for the EMG sample-FIFO write arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - clog2       : ceiling log2 helper for width derivation
//   - ARB_*_DEF   : default channel count / sample / ID widths, also used
//                   when sizing the sample FIFO that the arbiter feeds
// ---------------------------------------------------------------------------
package emg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int ARB_N_CH_DEF     = 4;
    localparam int ARB_SAMPLE_W_DEF = 12;
    localparam int ARB_ID_W_DEF     = clog2(ARB_N_CH_DEF);

endpackage

// File: rtl/emg_fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Searches the request vector
//   cyclically starting at the channel after the last grant.
//   Ports:
//     req_i   [N_CH]  request vector, bit i = channel i requesting
//     last_i  [ID_W]  index of the most recently granted channel
//     pick_o  [ID_W]  index of the winning channel (0 when valid_o=0)
//     valid_o         at least one channel is requesting
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [ID_W-1:0] last_i,
    output logic [ID_W-1:0] pick_o,
    output logic            valid_o
);

    logic found;

    // Two passes: channels strictly above last_i first, then wrap around to
    // channels 0..last_i. The first hit in that order wins.
    always_comb begin
        found  = 1'b0;
        pick_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req_i[i] && (ID_W'(i) > last_i)) begin
                found  = 1'b1;
                pick_o = ID_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req_i[i] && (ID_W'(i) <= last_i)) begin
                found  = 1'b1;
                pick_o = ID_W'(i);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/emg_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// emg_fifo_wr_arbiter
//   Round-robin write arbiter sharing one sample FIFO among N_CH EMG ADC
//   channels. Each grant takes one sample, tags it with the channel ID and
//   issues a single-cycle FIFO write. Never writes while fifo_full is high.
//
//   Handshake: ch_req[i] high means channel i holds a valid sample on
//   ch_data. The sample is taken in the cycle ch_ack[i] pulses (same cycle
//   as fifo_wr). The requester must drop ch_req or present new data within
//   2 cycles of the ack; the WRITE/GAP cycles guarantee it is not sampled
//   again before then.
//
//   Ports:
//     clk, reset    rising-edge clock, asynchronous active-high reset
//     en            arbiter enable (0 = no new grants)
//     ch_req        per-channel request
//     ch_data       packed samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
//     ch_ack        one-hot 1-cycle ack of the taken sample
//     fifo_full     FIFO full flag (registered inside the FIFO)
//     fifo_wr       1-cycle FIFO write strobe
//     fifo_w_data   {channel_id, sample}
//     grant_id      ID of the last granted channel
//     busy          high while in WRITE or GAP
//     wr_count      writes issued, saturating (only with ARB_STATS_EN)
//
//   Configuration macro: ARB_STATS_EN enables the wr_count counter;
//   without it wr_count is tied to zero.
//   All outputs are registered.
// ---------------------------------------------------------------------------
module emg_fifo_wr_arbiter
    import emg_arb_pkg::*;
#(
    parameter int N_CH     = ARB_N_CH_DEF,
    parameter int SAMPLE_W = ARB_SAMPLE_W_DEF,
    parameter int ID_W     = ARB_ID_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH*SAMPLE_W-1:0] ch_data,
    output logic [N_CH-1:0]          ch_ack,
    input  logic                     fifo_full,
    output logic                     fifo_wr,
    output logic [ID_W+SAMPLE_W-1:0] fifo_w_data,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic [15:0]              wr_count
);

    arb_state_t state_q, state_d;

    logic                     fifo_wr_q, fifo_wr_d;
    logic [N_CH-1:0]          ch_ack_q, ch_ack_d;
    logic [ID_W+SAMPLE_W-1:0] fifo_w_data_q, fifo_w_data_d;
    logic [ID_W-1:0]          grant_id_q, grant_id_d;
    logic                     busy_q, busy_d;

    logic [ID_W-1:0]     pick_id;
    logic                pick_valid;
    logic [SAMPLE_W-1:0] pick_sample;

    rr_pick #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_i   (ch_req),
        .last_i  (grant_id_q),
        .pick_o  (pick_id),
        .valid_o (pick_valid)
    );

    // Sample mux for the picked channel.
    always_comb begin
        pick_sample = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ID_W'(i) == pick_id) begin
                pick_sample = ch_data[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        fifo_wr_d     = 1'b0;
        ch_ack_d      = '0;
        fifo_w_data_d = fifo_w_data_q;
        grant_id_d    = grant_id_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = ARB;
            end
            ARB: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!fifo_full && pick_valid) begin
                    fifo_wr_d     = 1'b1;
                    fifo_w_data_d = {pick_id, pick_sample};
                    grant_id_d    = pick_id;
                    for (int i = 0; i < N_CH; i++) begin
                        ch_ack_d[i] = (ID_W'(i) == pick_id);
                    end
                    state_d = WRITE;
                end
            end
            // The write issued from ARB always completes; en is only
            // honoured once the GAP cycle is over.
            WRITE: state_d = GAP;
            // Dead cycle: lets the FIFO's registered full flag catch up.
            GAP:   state_d = en ? ARB : IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WRITE) || (state_d == GAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fifo_wr_q     <= 1'b0;
            ch_ack_q      <= '0;
            fifo_w_data_q <= '0;
            grant_id_q    <= ID_W'(N_CH - 1);
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifo_wr_q     <= fifo_wr_d;
            ch_ack_q      <= ch_ack_d;
            fifo_w_data_q <= fifo_w_data_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
        end
    end

    assign fifo_wr     = fifo_wr_q;
    assign ch_ack      = ch_ack_q;
    assign fifo_w_data = fifo_w_data_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;

`ifdef ARB_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;

    // Counts in step with the fifo_wr register so wr_count includes the
    // write currently on the bus.
    always_comb begin
        wr_count_d = wr_count_q;
        if (fifo_wr_d && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_count_q <= 16'h0000;
        else       wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;
`else
    assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_emg_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_emg_fifo_wr_arbiter
//   Directed bench for emg_fifo_wr_arbiter (N_CH=4, SAMPLE_W=12, ID_W=2).
//   Per-cycle vector table for reset, single grant, round-robin order and
//   en drop during a write; hand-written sequences for fifo_full blocking,
//   a 16-deep FIFO model, the 20-grant stats run and reset mid-WRITE.
// ---------------------------------------------------------------------------
module tb_emg_fifo_wr_arbiter;

    localparam int N_CH     = 4;
    localparam int SAMPLE_W = 12;
    localparam int ID_W     = 2;
    localparam int B        = ID_W + SAMPLE_W;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic                     en;
    logic [N_CH-1:0]          ch_req;
    logic [N_CH*SAMPLE_W-1:0] ch_data;
    logic [N_CH-1:0]          ch_ack;
    logic                     fifo_full;
    logic                     fifo_wr;
    logic [B-1:0]             fifo_w_data;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;
    logic [15:0]              wr_count;

    emg_fifo_wr_arbiter #(
        .N_CH     (N_CH),
        .SAMPLE_W (SAMPLE_W),
        .ID_W     (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .ch_req      (ch_req),
        .ch_data     (ch_data),
        .ch_ack      (ch_ack),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .wr_count    (wr_count)
    );

    // ---------------- 16-deep FIFO occupancy model (no reads) ----------------
    logic use_model;
    logic full_drv;
    int   model_count;
    logic model_full;

    always @(posedge clk or posedge reset) begin
        if (reset) model_count <= 0;
        else if (fifo_wr && model_count < 16) model_count <= model_count + 1;
    end
    assign model_full = (model_count == 16);
    assign fifo_full  = use_model ? model_full : full_drv;

    // ---------------- scoreboard ----------------
    logic [B-1:0]        exp_q[$];
    logic [SAMPLE_W-1:0] samples[N_CH];
    int checks;
    int errors;
    int mon_en;
    int writes;
    int wr_while_full;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        logic [B-1:0] e;
        @(posedge clk);
        #1;
        if (mon_en != 0 && fifo_wr) begin
            writes++;
            if (fifo_full) wr_while_full++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write: got %0h expected no write", fifo_w_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(fifo_w_data), 32'(e));
                check("sb_ack", 32'(ch_ack), 32'(1) << e[B-1 -: ID_W]);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b0;
        ch_req = '0;
        full_drv = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Expected round-robin writes with every channel requesting, from ch0.
    task automatic load_rr(input int n);
        logic [ID_W-1:0] id;
        for (int k = 0; k < n; k++) begin
            id = ID_W'(k % N_CH);
            exp_q.push_back({id, samples[k % N_CH]});
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            rst;
        logic            en;
        logic [N_CH-1:0] req;
        logic            full;
        logic            wr;
        logic [N_CH-1:0] ack;
        logic [B-1:0]    data;
        logic [ID_W-1:0] gid;
        logic            busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [3:0] rq, input logic f,
                       input logic w, input logic [3:0] a, input logic [13:0] d,
                       input logic [1:0] g, input logic b);
        vec_t v;
        v.rst = r; v.en = e; v.req = rq; v.full = f;
        v.wr = w; v.ack = a; v.data = d; v.gid = g; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        mon_en = 0;
        writes = 0;
        wr_while_full = 0;
        use_model = 1'b0;
        full_drv = 1'b0;
        en = 1'b0;
        ch_req = '0;
        reset = 1'b1;
        samples[0] = 12'h111;
        samples[1] = 12'h222;
        samples[2] = 12'hABC;
        samples[3] = 12'h333;
        ch_data = {samples[3], samples[2], samples[1], samples[0]};

        //   rst en  req     full  wr ack     data      gid busy
        // single request from channel 2
        add(1, 0, 4'b0000, 0,  0, 4'b0000, 14'h0000, 3, 0);
        add(0, 1, 4'b0100, 0,  0, 4'b0000, 14'h0000, 3, 0);
        add(0, 1, 4'b0100, 0,  1, 4'b0100, 14'h2ABC, 2, 1);
        add(0, 1, 4'b0000, 0,  0, 4'b0000, 14'h0000, 2, 1);
        add(0, 1, 4'b0000, 0,  0, 4'b0000, 14'h0000, 2, 0);
        add(0, 1, 4'b0000, 0,  0, 4'b0000, 14'h0000, 2, 0);
        // all channels requesting: 0,1,2,3,0 spaced 3 cycles
        add(1, 0, 4'b0000, 0,  0, 4'b0000, 14'h0000, 3, 0);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 3, 0);
        add(0, 1, 4'b1111, 0,  1, 4'b0001, 14'h0111, 0, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 0, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 0, 0);
        add(0, 1, 4'b1111, 0,  1, 4'b0010, 14'h1222, 1, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 1, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 1, 0);
        add(0, 1, 4'b1111, 0,  1, 4'b0100, 14'h2ABC, 2, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 2, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 2, 0);
        add(0, 1, 4'b1111, 0,  1, 4'b1000, 14'h3333, 3, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 3, 1);
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 3, 0);
        add(0, 1, 4'b1111, 0,  1, 4'b0001, 14'h0111, 0, 1);
        // en dropped while fifo_wr=1: write completes, FSM parks in IDLE
        add(0, 0, 4'b1111, 0,  0, 4'b0000, 14'h0000, 0, 1);
        add(0, 0, 4'b1111, 0,  0, 4'b0000, 14'h0000, 0, 0);
        add(0, 0, 4'b1111, 0,  0, 4'b0000, 14'h0000, 0, 0);
        add(0, 0, 4'b1111, 0,  0, 4'b0000, 14'h0000, 0, 0);
        // re-enable: IDLE->ARB, then next channel after 0
        add(0, 1, 4'b1111, 0,  0, 4'b0000, 14'h0000, 0, 0);
        add(0, 1, 4'b1111, 0,  1, 4'b0010, 14'h1222, 1, 1);

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            reset = v.rst;
            en = v.en;
            ch_req = v.req;
            full_drv = v.full;
            step();
            check($sformatf("vec%0d_wr", n), 32'(fifo_wr), 32'(v.wr));
            check($sformatf("vec%0d_ack", n), 32'(ch_ack), 32'(v.ack));
            check($sformatf("vec%0d_gid", n), 32'(grant_id), 32'(v.gid));
            check($sformatf("vec%0d_busy", n), 32'(busy), 32'(v.busy));
            if (v.wr) check($sformatf("vec%0d_data", n), 32'(fifo_w_data), 32'(v.data));
        end
        reset = 1'b0;

        // fifo_full blocks grants; releasing it grants the next channel
        do_reset();
        en = 1'b1;
        ch_req = 4'b0011;
        step();
        step();
        check("full_first_wr", 32'(fifo_wr), 32'd1);
        check("full_first_gid", 32'(grant_id), 32'd0);
        full_drv = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            check($sformatf("full_blk%0d_wr", c), 32'(fifo_wr), 32'd0);
            check($sformatf("full_blk%0d_ack", c), 32'(ch_ack), 32'd0);
        end
        full_drv = 1'b0;
        step();
        check("full_rel_wr", 32'(fifo_wr), 32'd1);
        check("full_rel_ack", 32'(ch_ack), 32'b0010);
        check("full_rel_gid", 32'(grant_id), 32'd1);
        check("full_rel_data", 32'(fifo_w_data), 32'h1222);

        // 20 back-to-back grants, wr_count tracks them when stats are built in
        do_reset();
        exp_q.delete();
        load_rr(20);
        writes = 0;
        mon_en = 1;
        en = 1'b1;
        ch_req = 4'b1111;
        for (int c = 0; c < 59; c++) step();
        mon_en = 0;
        check("g20_writes", 32'(writes), 32'd20);
        check("g20_sb_left", 32'(exp_q.size()), 32'd0);
        check("g20_wr_count", 32'(wr_count), STATS ? 32'd20 : 32'd0);

        // 16-deep FIFO, never read: exactly 16 writes, none while full
        do_reset();
        use_model = 1'b1;
        exp_q.delete();
        load_rr(16);
        writes = 0;
        wr_while_full = 0;
        mon_en = 1;
        en = 1'b1;
        ch_req = 4'b1111;
        for (int c = 0; c < 80; c++) step();
        mon_en = 0;
        check("fifo_writes", 32'(writes), 32'd16);
        check("fifo_full_flag", 32'(fifo_full), 32'd1);
        check("fifo_wr_while_full", 32'(wr_while_full), 32'd0);
        check("fifo_sb_left", 32'(exp_q.size()), 32'd0);
        check("fifo_wr_count", 32'(wr_count), STATS ? 32'd16 : 32'd0);
        use_model = 1'b0;

        // asynchronous reset in the middle of a WRITE cycle
        do_reset();
        en = 1'b1;
        ch_req = 4'b1111;
        step();
        step();
        check("rstw_pre_wr", 32'(fifo_wr), 32'd1);
        reset = 1'b1;
        #1;
        check("rstw_wr", 32'(fifo_wr), 32'd0);
        check("rstw_ack", 32'(ch_ack), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_data", 32'(fifo_w_data), 32'd0);
        check("rstw_gid", 32'(grant_id), 32'd3);
        check("rstw_wr_count", 32'(wr_count), 32'd0);
        step();
        reset = 1'b0;
        en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
